// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds clock generators, waits for lock and a slow-domain
// alignment edge, then releases NUM_DOMAINS resets in order. RESET_SEQ_RELOCK_EN enables re-sequencing on lock loss.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int CLKGEN_HOLD = 16,
    parameter int FIRST_DELAY = 64,
    parameter int RELEASE_GAP = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DOMAINS-1:0] locked,
    input  logic                   sync_ready,
    output logic                   reset_clkgen,
    output logic [NUM_DOMAINS-1:0] reset_domain,
    output logic                   running
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(CLKGEN_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] FIRST_LAST = CNT_WIDTH'(FIRST_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [5:0] {
        HOLD_CLKGEN = 6'b000001,
        WAIT_LOCKED = 6'b000010,
        WAIT_READY  = 6'b000100,
        COUNT_FIRST = 6'b001000,
        COUNT_GAP   = 6'b010000,
        RUNNING     = 6'b100000
    } state_t;

    // Held as a plain vector so any corrupted encoding is representable and recoverable.
    logic [5:0]             state;
    state_t                 state_nx;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic                   clkgen_nx, run_nx;
    logic [NUM_DOMAINS-1:0] dom_nx;
    logic                   lock_lost;

`ifdef RESET_SEQ_RELOCK_EN
    assign lock_lost = ~&locked;
`else
    assign lock_lost = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HOLD_CLKGEN;
            cnt          <= '0;
            idx          <= '0;
            reset_clkgen <= 1'b1;
            reset_domain <= '1;
            running      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            idx          <= idx_nx;
            reset_clkgen <= clkgen_nx;
            reset_domain <= dom_nx;
            running      <= run_nx;
        end
    end

    always_comb begin
        state_nx  = state_t'(state);
        cnt_nx    = cnt;
        idx_nx    = idx;
        clkgen_nx = reset_clkgen;
        dom_nx    = reset_domain;
        run_nx    = running;
        case (state)
            HOLD_CLKGEN: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == HOLD_LAST) begin
                    cnt_nx    = '0;
                    clkgen_nx = 1'b0;
                    state_nx  = WAIT_LOCKED;
                end
            end
            WAIT_LOCKED: if (&locked) state_nx = WAIT_READY;
            WAIT_READY: if (sync_ready) begin
                cnt_nx   = '0;
                state_nx = COUNT_FIRST;
            end
            COUNT_FIRST: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == FIRST_LAST) begin
                    cnt_nx    = '0;
                    dom_nx[0] = 1'b0;
                    if (NUM_DOMAINS == 1) begin
                        run_nx   = 1'b1;
                        state_nx = RUNNING;
                    end else begin
                        idx_nx   = IDX_W'(1);
                        state_nx = COUNT_GAP;
                    end
                end
            end
            COUNT_GAP: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_nx      = '0;
                    dom_nx[idx] = 1'b0;
                    if (idx == LAST_IDX) begin
                        run_nx   = 1'b1;
                        state_nx = RUNNING;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            RUNNING: ;
            default: begin
                state_nx  = HOLD_CLKGEN;
                cnt_nx    = '0;
                idx_nx    = '0;
                clkgen_nx = 1'b1;
                dom_nx    = '1;
                run_nx    = 1'b0;
            end
        endcase
        // Lock loss after sync restarts from WAIT_LOCKED with clock generators left running.
        if (lock_lost && (state == COUNT_FIRST || state == COUNT_GAP || state == RUNNING)) begin
            state_nx  = WAIT_LOCKED;
            cnt_nx    = '0;
            idx_nx    = '0;
            clkgen_nx = 1'b0;
            dom_nx    = '1;
            run_nx    = 1'b0;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (3 domains, 16/64/16 timing); expected
// outputs come from a release-edge timing model pushed through a scoreboard queue.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync_ready = 1'b0;
    logic [2:0] locked = 3'b000;
    logic       reset_clkgen, running;
    logic [2:0] reset_domain;
    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_DOMAINS(3), .CNT_WIDTH(8), .CLKGEN_HOLD(16), .FIRST_DELAY(64), .RELEASE_GAP(16)
    ) dut (
        .clk(clk), .reset(reset), .locked(locked), .sync_ready(sync_ready),
        .reset_clkgen(reset_clkgen), .reset_domain(reset_domain), .running(running)
    );

    typedef struct {
        logic       clkg;
        logic [2:0] dom;
        logic       run;
    } out_t;

    typedef struct {
        string name;
        int    partial_until;  // locked=011 on edges 1..partial_until
        int    ignored_sync;   // extra sync pulse edge expected to be ignored
        int    sync_start;
        int    sync_len;
        int    abort_edge;     // 0: run to completion
        int    exp_clk;
        int    exp_d0;
        int    exp_d1;
        int    exp_d2;
    } vec_t;

    out_t exp_q[$];
    vec_t vecs[5];

    function automatic out_t model(int n, int e_clk, int e0, int e1, int e2);
        out_t o;
        o.clkg = (n < e_clk);
        o.dom  = {(n < e2), (n < e1), (n < e0)};
        o.run  = (n >= e2);
        return o;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Push expectation for the coming edge, advance, pop and compare.
    task automatic step(string tag, out_t e);
        out_t x;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        edge_n++;
        x = exp_q.pop_front();
        check($sformatf("%s edge%0d", tag, edge_n),
              32'({reset_clkgen, reset_domain, running}), 32'({x.clkg, x.dom, x.run}));
    endtask

    task automatic do_reset(string tag);
        reset      = 1'b1;
        locked     = 3'b000;
        sync_ready = 1'b0;
        #1;
        check({tag, " reset_state"}, 32'({reset_clkgen, reset_domain, running}), 32'(5'b1_111_0));
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int last;
        vecs[0] = '{"basic",        0,  0, 20, 1,  0, 16,  84, 100, 116};
        vecs[1] = '{"partial_lock", 50, 30, 60, 1,  0, 16, 124, 140, 156};
        vecs[2] = '{"early_sync",   0,  10, 17, 2,  0, 16,  82,  98, 114};
        vecs[3] = '{"abort",        0,  0, 20, 1, 90, 16,  84, 100, 116};
        vecs[4] = '{"restart",      0,  0, 20, 1,  0, 16,  84, 100, 116};

        @(posedge clk);
        #1;
        foreach (vecs[v]) begin
            do_reset(vecs[v].name);
            last = (vecs[v].abort_edge != 0) ? vecs[v].abort_edge : vecs[v].exp_d2 + 4;
            for (int n = 1; n <= last; n++) begin
                locked     = (n <= vecs[v].partial_until) ? 3'b011 : 3'b111;
                sync_ready = (n == vecs[v].ignored_sync) ||
                             (n >= vecs[v].sync_start && n < vecs[v].sync_start + vecs[v].sync_len);
                step(vecs[v].name, model(n, vecs[v].exp_clk, vecs[v].exp_d0, vecs[v].exp_d1, vecs[v].exp_d2));
            end
            if (vecs[v].abort_edge != 0) begin
                sync_ready = 1'b0;
                #2;
                reset = 1'b1;
                #1;
                check("abort_async", 32'({reset_clkgen, reset_domain, running}), 32'(5'b1_111_0));
            end
        end

        // Lock drop on locked[1] while RUNNING, then a fresh sync pulse.
        for (int n = edge_n + 1; n <= 235; n++) begin
            out_t e;
            locked     = (n == 125) ? 3'b101 : 3'b111;
            sync_ready = (n == 130);
`ifdef RESET_SEQ_RELOCK_EN
            e = (n < 125) ? model(n, 16, 84, 100, 116) : model(n, 0, 194, 210, 226);
`else
            e = model(n, 16, 84, 100, 116);
`endif
            step("relock", e);
        end

        // Corrupt the state register; the next edge must recover to HOLD_CLKGEN.
        force dut.state = 6'b000011;
        #2;
        release dut.state;
        @(posedge clk);
        #1;
        check("illegal_state", 32'(dut.state), 32'(6'b000001));
        check("illegal_outputs", 32'({reset_clkgen, reset_domain, running}), 32'(5'b1_111_0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 2: number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the shared delay counter.
REQ-003 SHALL have parameter CLKGEN_HOLD, default 16: cycles reset_clkgen is held after reset release (1..2^CNT_WIDTH-1).
REQ-004 SHALL have parameter FIRST_DELAY, default 64: cycles from sync_ready acceptance to release of domain 0 (1..2^CNT_WIDTH-1).
REQ-005 SHALL have parameter RELEASE_GAP, default 16: cycles between consecutive domain releases (1..2^CNT_WIDTH-1).
REQ-006 SHALL have port clk, input, 1: single clock for all logic.
REQ-007 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-008 SHALL have port locked, input, NUM_DOMAINS: per-domain clock-generator lock flags.
REQ-009 SHALL have port sync_ready, input, 1: level pulse marking the slow-domain alignment edge (generalises the rs232 posedge indication).
REQ-010 SHALL have port reset_clkgen, output, 1: active-high reset to clock generators.
REQ-011 SHALL have port reset_domain, output, NUM_DOMAINS: active-high per-domain resets, bit 0 released first.
REQ-012 SHALL have port running, output, 1: high when all domains are released.

Function
REQ-013 SHALL implement states HOLD_CLKGEN, WAIT_LOCKED, WAIT_READY, COUNT_FIRST, COUNT_GAP, RUNNING, one-hot encoded.
REQ-014 HOLD_CLKGEN: counter increments each edge; on the CLKGEN_HOLD-th edge after reset deassertion, reset_clkgen clears and state goes to WAIT_LOCKED.
REQ-015 WAIT_LOCKED: on the first edge sampling locked all-ones, go to WAIT_READY; partial lock SHALL not advance.
REQ-016 WAIT_READY: on the first edge sampling sync_ready high, clear counter and go to COUNT_FIRST; sync_ready in any other state SHALL be ignored.
REQ-017 COUNT_FIRST: reset_domain[0] clears on the FIRST_DELAY-th edge after entry; counter clears; go to COUNT_GAP, or RUNNING if NUM_DOMAINS==1.
REQ-018 COUNT_GAP: reset_domain[i] clears RELEASE_GAP edges after reset_domain[i-1]; an internal index tracks i; after bit NUM_DOMAINS-1 clears, go to RUNNING.
REQ-019 running SHALL assert on the same edge the last reset_domain bit clears; released bits SHALL never re-assert except per REQ-024/REQ-025.
REQ-020 Counter SHALL compare with equality to (limit-1), never wrap within a state, and be CNT_WIDTH bits wide.
REQ-021 Unreachable/illegal state encodings SHALL recover to HOLD_CLKGEN with all resets asserted.

Reset
REQ-022 While reset is high: state=HOLD_CLKGEN, counter=0, index=0, reset_clkgen=1, reset_domain=all ones, running=0, asynchronously.
REQ-023 Reset asserted mid-sequence SHALL abort immediately to the REQ-022 values; sequence restarts from REQ-014 on release.

Configuration
REQ-024 Macro RESET_SEQ_RELOCK_EN defined: in COUNT_FIRST, COUNT_GAP or RUNNING, any locked bit sampled low SHALL on that edge set reset_domain all ones, running=0, counter=0, index=0, keep reset_clkgen=0, and go to WAIT_LOCKED.
REQ-025 Macro RESET_SEQ_RELOCK_EN undefined: locked SHALL be ignored outside WAIT_LOCKED; once RUNNING, the block stays RUNNING until reset.

Verification (NUM_DOMAINS=3, CLKGEN_HOLD=16, FIRST_DELAY=64, RELEASE_GAP=16)
REQ-026 Release reset, locked=3'b111, sync_ready pulse at edge 20 -> reset_clkgen falls edge 16; reset_domain[0] falls edge 84, [1] edge 100, [2] edge 116; running rises edge 116.
REQ-027 locked=3'b011 held 50 cycles then 3'b111 -> state stays WAIT_LOCKED, all reset_domain high until lock complete; sync_ready pulses during wait ignored.
REQ-028 Assert reset at edge 90 (domain 0 released) -> all outputs return to REQ-022 values without waiting for an edge; full sequence repeats after release.
REQ-029 With RESET_SEQ_RELOCK_EN, drop locked[1] for one cycle in RUNNING -> reset_domain=3'b111, running=0 next edge, reset_clkgen stays 0; new sync_ready re-runs 64/16/16 timing.
REQ-030 Without RESET_SEQ_RELOCK_EN, same stimulus as REQ-029 -> no output change; running stays 1.
REQ-031 Force illegal state encoding via bench -> next edge state HOLD_CLKGEN, all resets asserted.
